// File: rtl/cordic_pkg.sv
// Shared definitions for the cordic scheduler: coordinate/operation mode encodings,
// the FSM state type and the Q16.16 inverse CORDIC gain.
package cordic_pkg;

    localparam logic [1:0]  CIRCULAR  = 2'b01;
    localparam logic [1:0]  LINEAR    = 2'b00;
    localparam logic        ROTATION  = 1'b0;
    localparam logic        VECTORING = 1'b1;

    // 1/K in Q16.16, used by clients to pre-scale x for unity-gain rotation
    localparam logic [31:0] K_INV     = 32'h0000_9B74;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. Searches req_i upward from ptr_i, wrapping, and grants
// the first set bit. The pointer register is owned by the instantiating block.
//
// Ports:
//   req_i      request vector
//   ptr_i      index with highest priority this cycle
//   gnt_o      one-hot grant (all zero when no request)
//   gnt_idx_o  binary index of the granted requester
//   any_o      at least one request present
module rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] gnt_idx_o,
    output logic          any_o
);

    logic found;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && req_i[PW'((32'(ptr_i) + i) % N)]) begin
                found                              = 1'b1;
                gnt_o[PW'((32'(ptr_i) + i) % N)]   = 1'b1;
                gnt_idx_o                          = PW'((32'(ptr_i) + i) % N);
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/cordic_scheduler.sv
// Shares one cordic core between NREQ requesters. Grants round-robin, one operation per
// grant: latches the winner's operands into the core_* registers, pulses core_enable, waits
// for core_valid, then returns the result on resp_* with a one-hot resp_valid to the owner.
//
// Optional feature: define CORDIC_TIMEOUT_EN to add a WAIT-state watchdog. After
// TIMEOUT_CYCLES cycles in WAIT without core_valid the op completes with resp_* = 0 and
// resp_err = 1. Without the macro there is no counter and resp_err is tied to 0.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   req_valid/req_ready             per-requester handshake (req_ready one-hot)
//   req_mode_op/req_mode_coord      per-requester modes
//   req_x/req_y/req_z               per-requester operands, slice i = [i*WIDTH +: WIDTH]
//   resp_valid                      one-hot 1-cycle result pulse to the owner
//   resp_x/resp_y/resp_z/resp_err   shared result bus, held after the pulse
//   busy                            high in every state except IDLE
//   core_enable                     1-cycle start pulse to the core
//   core_mode_op/core_mode_coord    registered modes to the core
//   core_x/core_y/core_z            registered operands to the core
//   core_x_out/core_y_out/core_z_out, core_valid   core results and done pulse
module cordic_scheduler
    import cordic_pkg::*;
#(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned NREQ           = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ-1:0]       req_mode_op,
    input  logic [2*NREQ-1:0]     req_mode_coord,
    input  logic [NREQ*WIDTH-1:0] req_x,
    input  logic [NREQ*WIDTH-1:0] req_y,
    input  logic [NREQ*WIDTH-1:0] req_z,
    output logic [NREQ-1:0]       resp_valid,
    output logic [WIDTH-1:0]      resp_x,
    output logic [WIDTH-1:0]      resp_y,
    output logic [WIDTH-1:0]      resp_z,
    output logic                  resp_err,
    output logic                  busy,
    output logic                  core_enable,
    output logic                  core_mode_op,
    output logic [1:0]            core_mode_coord,
    output logic [WIDTH-1:0]      core_x,
    output logic [WIDTH-1:0]      core_y,
    output logic [WIDTH-1:0]      core_z,
    input  logic [WIDTH-1:0]      core_x_out,
    input  logic [WIDTH-1:0]      core_y_out,
    input  logic [WIDTH-1:0]      core_z_out,
    input  logic                  core_valid
);

    localparam int unsigned PW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("cordic_scheduler: NREQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q;
    logic [NREQ-1:0]   owner_q;
    logic              core_mode_op_q;
    logic [1:0]        core_mode_coord_q;
    logic [WIDTH-1:0]  core_x_q, core_y_q, core_z_q;
    logic [WIDTH-1:0]  resp_x_q, resp_y_q, resp_z_q;

    logic [NREQ-1:0]   gnt;
    logic [PW-1:0]     gnt_idx;
    logic              any_req;
    logic              accept;
    logic              timeout;

    logic              sel_m;
    logic [1:0]        sel_c;
    logic [WIDTH-1:0]  sel_x, sel_y, sel_z;

    rr_arbiter #(
        .N  (NREQ),
        .PW (PW)
    ) u_arb (
        .req_i     (req_valid),
        .ptr_i     (ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .any_o     (any_req)
    );

    assign accept = (state_q == IDLE) && any_req;

    // Operand mux for the granted requester
    always_comb begin
        sel_m = 1'b0;
        sel_c = '0;
        sel_x = '0;
        sel_y = '0;
        sel_z = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_idx == PW'(i)) begin
                sel_m = req_mode_op[i];
                sel_c = req_mode_coord[2*i +: 2];
                sel_x = req_x[i*WIDTH +: WIDTH];
                sel_y = req_y[i*WIDTH +: WIDTH];
                sel_z = req_z[i*WIDTH +: WIDTH];
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (any_req) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (core_valid || timeout) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs. req_ready is gated during reset so no transfer can be lost to it.
    always_comb begin
        req_ready   = (accept && !rst) ? gnt : '0;
        resp_valid  = (state_q == RESP) ? owner_q : '0;
        busy        = (state_q != IDLE);
        core_enable = (state_q == ISSUE);
    end

    // Datapath: operand latch, round-robin pointer, result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q             <= '0;
            owner_q           <= '0;
            core_mode_op_q    <= 1'b0;
            core_mode_coord_q <= '0;
            core_x_q          <= '0;
            core_y_q          <= '0;
            core_z_q          <= '0;
            resp_x_q          <= '0;
            resp_y_q          <= '0;
            resp_z_q          <= '0;
        end else begin
            if (accept) begin
                owner_q           <= gnt;
                ptr_q             <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
                core_mode_op_q    <= sel_m;
                core_mode_coord_q <= sel_c;
                core_x_q          <= sel_x;
                core_y_q          <= sel_y;
                core_z_q          <= sel_z;
            end
            if (state_q == WAIT) begin
                if (core_valid) begin
                    resp_x_q <= core_x_out;
                    resp_y_q <= core_y_out;
                    resp_z_q <= core_z_out;
                end else if (timeout) begin
                    resp_x_q <= '0;
                    resp_y_q <= '0;
                    resp_z_q <= '0;
                end
            end
        end
    end

`ifdef CORDIC_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic            resp_err_q;

    // Fires on the last of TIMEOUT_CYCLES WAIT cycles; a same-cycle core_valid wins.
    assign timeout = (state_q == WAIT) && !core_valid &&
                     (tmo_cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == ISSUE) begin
            tmo_cnt_d = '0;
        end else if (state_q == WAIT) begin
            tmo_cnt_d = tmo_cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q  <= '0;
            resp_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            if (state_q == WAIT) begin
                if (core_valid) begin
                    resp_err_q <= 1'b0;
                end else if (timeout) begin
                    resp_err_q <= 1'b1;
                end
            end
        end
    end

    assign resp_err = resp_err_q;
`else
    assign timeout  = 1'b0;
    assign resp_err = 1'b0;
`endif

    assign core_mode_op    = core_mode_op_q;
    assign core_mode_coord = core_mode_coord_q;
    assign core_x          = core_x_q;
    assign core_y          = core_y_q;
    assign core_z          = core_z_q;
    assign resp_x          = resp_x_q;
    assign resp_y          = resp_y_q;
    assign resp_z          = resp_z_q;

endmodule

// File: tb/tb_cordic_scheduler.sv
// Bench for cordic_scheduler: a behavioural stand-in core, a round-robin grant model and a
// scoreboard of expected responses popped by an independent response monitor.
module tb_cordic_scheduler;
    import cordic_pkg::*;

    localparam int W   = 32;
    localparam int N   = 4;
    localparam int TMO = 8;
    localparam real KGAIN = 1.6467602581210656;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]   req_valid, req_ready, req_mode_op, resp_valid;
    logic [2*N-1:0] req_mode_coord;
    logic [N*W-1:0] req_x, req_y, req_z;
    logic [W-1:0]   resp_x, resp_y, resp_z;
    logic           resp_err, busy, core_enable, core_mode_op, core_valid;
    logic [1:0]     core_mode_coord;
    logic [W-1:0]   core_x, core_y, core_z, core_x_out, core_y_out, core_z_out;

    logic [W-1:0] op_x [N];
    logic [W-1:0] op_y [N];
    logic [W-1:0] op_z [N];
    logic         op_m [N];
    logic [1:0]   op_c [N];

    always_comb begin
        req_x = '0; req_y = '0; req_z = '0; req_mode_op = '0; req_mode_coord = '0;
        for (int i = 0; i < N; i++) begin
            req_x[i*W +: W]          = op_x[i];
            req_y[i*W +: W]          = op_y[i];
            req_z[i*W +: W]          = op_z[i];
            req_mode_op[i]           = op_m[i];
            req_mode_coord[2*i +: 2] = op_c[i];
        end
    end

    cordic_scheduler #(
        .WIDTH          (W),
        .NREQ           (N),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_mode_op     (req_mode_op),
        .req_mode_coord  (req_mode_coord),
        .req_x           (req_x),
        .req_y           (req_y),
        .req_z           (req_z),
        .resp_valid      (resp_valid),
        .resp_x          (resp_x),
        .resp_y          (resp_y),
        .resp_z          (resp_z),
        .resp_err        (resp_err),
        .busy            (busy),
        .core_enable     (core_enable),
        .core_mode_op    (core_mode_op),
        .core_mode_coord (core_mode_coord),
        .core_x          (core_x),
        .core_y          (core_y),
        .core_z          (core_z),
        .core_x_out      (core_x_out),
        .core_y_out      (core_y_out),
        .core_z_out      (core_z_out),
        .core_valid      (core_valid)
    );

    typedef struct {
        int         id;
        logic [W-1:0] x, y, z;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   grant_log[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc = 0;
    int   model_ptr = 0;
    int   resp_cnt = 0, resp_cyc = 0;
    int   enable_cyc = 0, lat_used = 0, n_enables = 0;
    int   core_lat = 3;
    bit   core_lat_rand = 1'b0;
    bit   expect_timeout = 1'b0;
    int   stray_req = 0, stray_ack = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_tol(input string name, input logic [W-1:0] act, input logic [W-1:0] exp,
                             input int tol);
        int d;
        d = $signed(act) - $signed(exp);
        n_tests++;
        if (d > tol || d < -tol) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h +/- 0x%0h", name, act, exp, tol);
        end
    endtask

    // Stand-in core behaviour: true rotations for CIRCULAR/LINEAR rotation mode, an arbitrary
    // deterministic mix otherwise. Only routing and timing of the scheduler are under test.
    function automatic void core_fn(input logic m, input logic [1:0] c,
                                    input logic [W-1:0] x, input logic [W-1:0] y,
                                    input logic [W-1:0] z, output logic [W-1:0] xo,
                                    output logic [W-1:0] yo, output logic [W-1:0] zo);
        real xr, yr, zr;
        longint p;
        if (c == CIRCULAR && m == ROTATION) begin
            xr = $itor($signed(x)) / 65536.0;
            yr = $itor($signed(y)) / 65536.0;
            zr = $itor($signed(z)) / 65536.0;
            xo = 32'($rtoi(KGAIN * (xr * $cos(zr) - yr * $sin(zr)) * 65536.0));
            yo = 32'($rtoi(KGAIN * (xr * $sin(zr) + yr * $cos(zr)) * 65536.0));
            zo = '0;
        end else if (c == LINEAR && m == ROTATION) begin
            p  = longint'($signed(x)) * longint'($signed(z));
            xo = x;
            yo = y + 32'(p >>> 16);
            zo = '0;
        end else begin
            xo = x + 32'h1111;
            yo = y ^ z;
            zo = z - x;
        end
    endfunction

    function automatic logic [W-1:0] rnd18();
        return 32'($urandom_range(0, 262143)) - 32'd131072;
    endfunction

    task automatic set_op(input int i, input logic m, input logic [1:0] c,
                          input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] z);
        op_m[i] = m; op_c[i] = c; op_x[i] = x; op_y[i] = y; op_z[i] = z;
        req_valid[i] = 1'b1;
    endtask

    task automatic raise_rand(input int i);
        logic [1:0] c;
        c = 2'($urandom_range(0, 2));
        set_op(i, 1'($urandom_range(0, 1)), c, rnd18(), rnd18(), rnd18());
    endtask

    // Called at the negedge where req_ready is seen; the transfer happens at the next posedge.
    task automatic on_accept(output logic [N-1:0] acc);
        int g;
        exp_t e;
        g = -1;
        for (int k = 0; k < N; k++) begin
            if (g < 0 && req_valid[(model_ptr + k) % N]) g = (model_ptr + k) % N;
        end
        if (g < 0) g = 0;
        check("grant", 64'(req_ready), 64'(1 << g));
        check("one_outstanding", 64'(sb.size()), 64'd0);
        e.id = g;
        if (expect_timeout) begin
            e.x = '0; e.y = '0; e.z = '0; e.err = 1'b1;
        end else begin
            core_fn(op_m[g], op_c[g], op_x[g], op_y[g], op_z[g], e.x, e.y, e.z);
            e.err = 1'b0;
        end
        sb.push_back(e);
        grant_log.push_back(g);
        model_ptr = (g + 1) % N;
        acc = req_ready;
    endtask

    // Runs until n_ops operations (including ones already pending) have been accepted.
    task automatic run_engine(input int n_ops, input int p_new, input bit drain);
        int issued, done, budget;
        logic [N-1:0] acc;
        issued = $countones(req_valid);
        done   = 0;
        budget = n_ops * 40 + 100;
        while (done < n_ops && budget > 0) begin
            @(negedge clk);
            budget--;
            acc = '0;
            if (req_ready != 0) begin
                on_accept(acc);
                done++;
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acc[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && issued < n_ops && $urandom_range(0, 99) < p_new) begin
                    raise_rand(i);
                    issued++;
                end
            end
        end
        if (done < n_ops) begin
            n_tests++; n_fail++;
            $display("FAIL accept_budget: accepted %0d, required %0d", done, n_ops);
            req_valid = '0;
        end
        if (drain) begin
            budget = 60;
            while (sb.size() != 0 && budget > 0) begin
                @(negedge clk);
                budget--;
            end
            check("drain_pending", 64'(sb.size()), 64'd0);
        end
    endtask

    // Stand-in core
    initial begin : core_model
        logic [W-1:0] a, b, c;
        int  lat, k;
        bit  abort;
        core_valid = 1'b0; core_x_out = '0; core_y_out = '0; core_z_out = '0;
        forever begin
            @(negedge clk);
            if (core_enable) begin
                lat = core_lat_rand ? int'($urandom_range(1, 6)) : core_lat;
                enable_cyc = cyc;
                lat_used   = lat;
                n_enables++;
                core_fn(core_mode_op, core_mode_coord, core_x, core_y, core_z, a, b, c);
                k = 0; abort = 1'b0;
                while (k < lat && !abort) begin
                    @(posedge clk);
                    if (rst) abort = 1'b1;
                    k++;
                end
                if (!abort) begin
                    #1;
                    core_valid = 1'b1; core_x_out = a; core_y_out = b; core_z_out = c;
                    @(posedge clk);
                    #1;
                    core_valid = 1'b0;
                end
            end else if (stray_req != stray_ack) begin
                stray_ack++;
                @(posedge clk);
                #1;
                core_valid = 1'b1;
                core_x_out = 32'hDEAD_BEEF; core_y_out = 32'hCAFE_F00D; core_z_out = 32'h1234_5678;
                @(posedge clk);
                #1;
                core_valid = 1'b0;
            end
        end
    end

    // Response monitor
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (resp_valid != 0) begin
                resp_cnt++;
                resp_cyc = cyc;
                if (sb.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_resp: resp_valid=%b, required no response", resp_valid);
                end else begin
                    e = sb.pop_front();
                    check("resp_valid", 64'(resp_valid), 64'(1 << e.id));
                    check("resp_x", 64'(resp_x), 64'(e.x));
                    check("resp_y", 64'(resp_y), 64'(e.y));
                    check("resp_z", 64'(resp_z), 64'(e.z));
                    check("resp_err", 64'(resp_err), 64'(e.err));
                    check("resp_latency", 64'(resp_cyc - enable_cyc),
                          64'(e.err ? TMO + 1 : lat_used + 1));
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "global timeout");
    end

    initial begin : main
        int c0, e0;
        int exp_seq[5];
        exp_seq = '{0, 1, 2, 3, 0};
        req_valid = '0;
        for (int i = 0; i < N; i++) begin
            op_x[i] = '0; op_y[i] = '0; op_z[i] = '0; op_m[i] = 1'b0; op_c[i] = '0;
        end

        // Reset state, with a request held during reset
        repeat (2) @(posedge clk);
        #1;
        req_valid[1] = 1'b1;
        @(posedge clk);
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_core_enable", 64'(core_enable), 64'd0);
        check("rst_core_x", 64'(core_x), 64'd0);
        check("rst_core_coord", 64'(core_mode_coord), 64'd0);
        check("rst_resp_x", 64'(resp_x), 64'd0);
        check("rst_resp_err", 64'(resp_err), 64'd0);
        req_valid = '0;
        rst = 1'b0;

        // Single CIRCULAR rotation by 30 degrees
        @(posedge clk);
        #1;
        core_lat = 4;
        set_op(0, ROTATION, CIRCULAR, K_INV, 32'h0, 32'h0000_860A);
        run_engine(1, 0, 1'b1);
        check_tol("t1_resp_y", resp_y, 32'h0000_8000, 'h40);
        check_tol("t1_resp_x", resp_x, 32'h0000_DDB3, 'h40);
        check("t1_resp_err", 64'(resp_err), 64'd0);

        // LINEAR: 2.0 * 1.5
        @(posedge clk);
        #1;
        set_op(2, ROTATION, LINEAR, 32'h0002_0000, 32'h0, 32'h0001_8000);
        run_engine(1, 0, 1'b1);
        check_tol("t2_resp_y", resp_y, 32'h0003_0000, 'h10);

        // All four requesting from reset
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        model_ptr = 0;
        for (int i = 0; i < N; i++) raise_rand(i);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        grant_log.delete();
        run_engine(8, 100, 1'b1);
        check("t3_grant_count", 64'(grant_log.size()), 64'd8);
        for (int i = 0; i < 5 && i < grant_log.size(); i++) begin
            check("t3_grant_order", 64'(grant_log[i]), 64'(exp_seq[i]));
        end

        // Reset pulse during WAIT abandons the op and resets the pointer
        @(posedge clk);
        #1;
        core_lat = 20;
        set_op(0, VECTORING, CIRCULAR, rnd18(), rnd18(), rnd18());
        run_engine(1, 0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        model_ptr = 0;
        c0 = resp_cnt;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("t4_busy_after_rst", 64'(busy), 64'd0);
        core_lat = 3;
        set_op(2, ROTATION, LINEAR, rnd18(), rnd18(), rnd18());
        set_op(0, ROTATION, LINEAR, rnd18(), rnd18(), rnd18());
        grant_log.delete();
        run_engine(2, 0, 1'b1);
        check("t4_grant_count", 64'(grant_log.size()), 64'd2);
        if (grant_log.size() > 0) check("t4_first_grant", 64'(grant_log[0]), 64'd0);
        check("t4_resp_count", 64'(resp_cnt - c0), 64'd2);

        // Stray core_valid while idle
        c0 = resp_cnt;
        stray_req++;
        repeat (6) @(negedge clk);
        check("t5_busy_idle", 64'(busy), 64'd0);
        check("t5_no_resp", 64'(resp_cnt - c0), 64'd0);
        @(posedge clk);
        #1;
        set_op(1, ROTATION, CIRCULAR, rnd18(), rnd18(), rnd18());
        run_engine(1, 0, 1'b1);
        check("t5_one_resp", 64'(resp_cnt - c0), 64'd1);

        // Identical operands still get two core runs
        @(posedge clk);
        #1;
        e0 = n_enables;
        set_op(1, ROTATION, LINEAR, 32'h0001_0000, 32'h0000_4000, 32'h0000_2000);
        set_op(3, ROTATION, LINEAR, 32'h0001_0000, 32'h0000_4000, 32'h0000_2000);
        run_engine(2, 0, 1'b1);
        check("t_dup_core_runs", 64'(n_enables - e0), 64'd2);

        // Randomised traffic with random core latency
        core_lat_rand = 1'b1;
        @(posedge clk);
        #1;
        run_engine(40, 30, 1'b1);
        core_lat_rand = 1'b0;

`ifdef CORDIC_TIMEOUT_EN
        // Core answers far too late: watchdog completes the op, late core_valid ignored
        @(posedge clk);
        #1;
        c0 = resp_cnt;
        core_lat = 14;
        expect_timeout = 1'b1;
        set_op(3, ROTATION, CIRCULAR, rnd18(), rnd18(), rnd18());
        run_engine(1, 0, 1'b1);
        expect_timeout = 1'b0;
        repeat (20) @(negedge clk);
        check("t6_single_resp", 64'(resp_cnt - c0), 64'd1);
        check("t6_busy_after", 64'(busy), 64'd0);
        core_lat = 3;
`endif

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
